hit_rate_monitor: RTL and testbench

HIT_RATE_MONITOR -- requirements
Module: hit_rate_monitor

---
 rtl/hit_rate_monitor.sv | 154 +++++++++++++++
 tb/tb_hit_rate_monitor.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/hit_rate_monitor.sv
// hit_rate_monitor
//   Counts cache accesses and hits. On request it computes the hit rate as
//   floor(100 * hits / accesses) with a serial restoring divider.
//
// Ports
//   clk           in   single clock, rising edge
//   rst           in   synchronous, active-high reset
//   access_valid  in   one-cycle pulse per completed cache access
//   access_hit    in   hit flag, qualified by access_valid
//   clear         in   pulse, zeroes both counters (does not touch the divider)
//   finish        in   pulse, starts a hit-rate computation (taken in IDLE only)
//   access_count  out  [CNT_W]  qualified access count, saturating
//   hit_count     out  [CNT_W]  qualified hit count, saturating
//   hit_rate      out  [RATE_W] result of the last completed computation
//   busy          out  high while the divider runs
//   done          out  one-cycle pulse when a result has been loaded
module hit_rate_monitor #(
  parameter int CNT_W  = 14,
  parameter int RATE_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              access_valid,
  input  logic              access_hit,
  input  logic              clear,
  input  logic              finish,
  output logic [CNT_W-1:0]  access_count,
  output logic [CNT_W-1:0]  hit_count,
  output logic [RATE_W-1:0] hit_rate,
  output logic              busy,
  output logic              done
);

  localparam int DIV_W  = CNT_W + RATE_W;
  localparam int ITER_W = $clog2(DIV_W);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(DIV_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [DIV_W-1:0]  PCT_SCALE = DIV_W'(100);

  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    hit_q, hit_d;
  logic [RATE_W-1:0]   rate_q, rate_d;

  // Divider datapath: no reset needed, it is always loaded before use.
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [CNT_W-1:0]    divisor_q, divisor_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [DIV_W-1:0]    quo_q, quo_d;

  logic [CNT_W:0]      trial;
  logic [CNT_W:0]      diff;
  logic [CNT_W-1:0]    rem_step;
  logic [DIV_W-1:0]    quo_step;

  // Counters: clear wins over a same-cycle access. Once access_count is at
  // its maximum both counters freeze, which keeps hit_count <= access_count.
  always_comb begin
    acc_d = acc_q;
    hit_d = hit_q;
    if (clear) begin
      acc_d = '0;
      hit_d = '0;
    end else if (access_valid && (acc_q != CNT_MAX)) begin
      acc_d = acc_q + 1'b1;
      if (access_hit) begin
        hit_d = hit_q + 1'b1;
      end
    end
  end

  // One restoring-division step. quo_q starts as the dividend and shifts
  // left, taking quotient bits in at the bottom. The remainder is always
  // below the divisor, so trial < 2*divisor and the borrow bit of diff is
  // exactly "trial < divisor".
  always_comb begin
    trial    = {rem_q, quo_q[DIV_W-1]};
    diff     = trial - {1'b0, divisor_q};
    rem_step = trial[CNT_W-1:0];
    quo_step = {quo_q[DIV_W-2:0], 1'b0};
    if (!diff[CNT_W]) begin
      rem_step = diff[CNT_W-1:0];
      quo_step = {quo_q[DIV_W-2:0], 1'b1};
    end
  end

  always_comb begin
    state_d   = state_q;
    rate_d    = rate_q;
    iter_d    = iter_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    case (state_q)
      IDLE: begin
        if (finish) begin
          if (acc_q == '0) begin
            rate_d  = '0;
            state_d = DONE;
          end else begin
            // Snapshot: later accesses keep counting but do not disturb this run.
            divisor_d = acc_q;
            quo_d     = {{RATE_W{1'b0}}, hit_q} * PCT_SCALE;
            rem_d     = '0;
            iter_d    = '0;
            state_d   = DIVIDE;
          end
        end
      end
      DIVIDE: begin
        rem_d  = rem_step;
        quo_d  = quo_step;
        iter_d = iter_q + 1'b1;
        if (iter_q == LAST_ITER) begin
          // hits <= accesses bounds the quotient at 100, so the low bits hold it all.
          rate_d  = quo_step[RATE_W-1:0];
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      hit_q   <= '0;
      rate_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      hit_q   <= hit_d;
      rate_q  <= rate_d;
    end
  end

  always_ff @(posedge clk) begin
    iter_q    <= iter_d;
    divisor_q <= divisor_d;
    rem_q     <= rem_d;
    quo_q     <= quo_d;
  end

  assign access_count = acc_q;
  assign hit_count    = hit_q;
  assign hit_rate     = rate_q;
  assign busy         = (state_q == DIVIDE);
  assign done         = (state_q == DONE);

endmodule

// File: tb/tb_hit_rate_monitor.sv
// Testbench for hit_rate_monitor: directed and randomized access streams,
// compared against a plain-arithmetic model of the counters and hit rate.
module tb_hit_rate_monitor;
  localparam int CNT_W  = 14;
  localparam int RATE_W = 7;
  localparam int MAXC   = (1 << CNT_W) - 1;
  localparam int DIV_CYCLES = CNT_W + RATE_W;

  logic clk = 1'b0;
  logic rst = 1'b0, access_valid = 1'b0, access_hit = 1'b0, clear = 1'b0, finish = 1'b0;
  logic [CNT_W-1:0]  access_count, hit_count;
  logic [RATE_W-1:0] hit_rate;
  logic busy, done;

  int checks = 0;
  int errors = 0;
  int m_acc  = 0;
  int m_hit  = 0;
  int m_rate = 0;

  always #5 clk = ~clk;

  hit_rate_monitor #(.CNT_W(CNT_W), .RATE_W(RATE_W)) dut (
    .clk(clk), .rst(rst), .access_valid(access_valid), .access_hit(access_hit),
    .clear(clear), .finish(finish), .access_count(access_count),
    .hit_count(hit_count), .hit_rate(hit_rate), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, step the edge, update the model, compare.
  task automatic tick(input bit r, input bit av, input bit ah, input bit clr,
                      input bit fin, input bit idle);
    rst = r; access_valid = av; access_hit = ah; clear = clr; finish = fin;
    @(posedge clk); #1;
    if (r) begin
      m_acc = 0; m_hit = 0; m_rate = 0;
    end else if (clr) begin
      m_acc = 0; m_hit = 0;
    end else if (av && m_acc < MAXC) begin
      m_acc++;
      if (ah) m_hit++;
    end
    rst = 0; access_valid = 0; access_hit = 0; clear = 0; finish = 0;
    chk("access_count", access_count, m_acc);
    chk("hit_count", hit_count, m_hit);
    chk("hit_rate", hit_rate, m_rate);
    if (idle) begin
      chk("busy_idle", busy, 0);
      chk("done_idle", done, 0);
    end
  endtask

  // Feed n accesses, the first nh of them hits; optional random gaps.
  task automatic feed(input int n, input int nh, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) tick(0, 0, 0, 0, 0, 1);
      tick(0, 1, (i < nh), 0, 0, 1);
    end
  endtask

  // Feed n accesses with random hits.
  task automatic feed_rand(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) tick(0, 0, 0, 0, 0, 1);
      tick(0, 1, bit'($urandom_range(0, 1)), 0, 0, 1);
    end
  endtask

  // Request a computation and follow it to the end. During the divide:
  // n_hits forced hits, clear at iteration clr_at (-1 = none), and if noise
  // is set, random accesses plus stray finish pulses.
  task automatic do_finish(input bit noise, input int n_hits, input int clr_at);
    int exp_rate;
    exp_rate = (m_acc == 0) ? 0 : (m_hit * 100) / m_acc;
    if (m_acc == 0) begin
      m_rate = 0;
      tick(0, 0, 0, 0, 1, 0);
      chk("done_zero", done, 1);
      chk("busy_zero", busy, 0);
      tick(0, 0, 0, 0, noise, 1);
      tick(0, 0, 0, 0, 0, 1);
    end else begin
      tick(0, 0, 0, 0, 1, 0);
      for (int i = 0; i < DIV_CYCLES; i++) begin
        bit av, ah, fn;
        chk("busy_div", busy, 1);
        chk("done_div", done, 0);
        av = (i < n_hits) || (noise && $urandom_range(0, 1) == 1);
        ah = (i < n_hits) || ($urandom_range(0, 1) == 1);
        fn = noise && $urandom_range(0, 2) == 0;
        if (i == DIV_CYCLES - 1) m_rate = exp_rate;
        tick(0, av, ah, (i == clr_at), fn, 0);
      end
      chk("done_pulse", done, 1);
      chk("busy_end", busy, 0);
      chk("rate_value", hit_rate, exp_rate);
      tick(0, 0, 0, 0, noise, 1);
      tick(0, 0, 0, 0, 0, 1);
    end
  endtask

  initial begin
    // Reset held for two cycles
    tick(1, 1, 1, 0, 1, 1);
    tick(1, 0, 0, 0, 0, 1);
    chk("reset_rate", hit_rate, 0);

    // 8 accesses, 6 hits -> 75
    feed(8, 6, 0);
    do_finish(0, 0, -1);
    chk("rate75", hit_rate, 75);
    chk("cnt8", access_count, 8);
    chk("hit6", hit_count, 6);

    // 3 accesses, 1 hit -> 33, stray finish pulses ignored
    tick(0, 0, 0, 1, 0, 1);
    feed(3, 1, 0);
    tick(0, 0, 0, 0, 0, 1);
    m_acc = m_acc; // counters persist; nothing else to adjust
    do_finish(1, 0, -1);

    // Zero accesses -> immediate done, rate 0
    tick(0, 0, 0, 1, 0, 1);
    do_finish(1, 0, -1);
    chk("rate0", hit_rate, 0);

    // Saturation: 16400 hits
    feed(16400, 16400, 0);
    chk("sat_acc", access_count, MAXC);
    chk("sat_hit", hit_count, MAXC);
    do_finish(0, 0, -1);
    chk("rate100", hit_rate, 100);

    // 4 accesses, 1 hit; two hits then clear while dividing -> 25, counters 0
    tick(0, 0, 0, 1, 0, 1);
    feed(4, 1, 0);
    do_finish(0, 2, 5);
    chk("rate25", hit_rate, 25);
    chk("clr_acc", access_count, 0);
    chk("clr_hit", hit_count, 0);

    // Randomized streams with noise during the divide
    for (int t = 0; t < 6; t++) begin
      if ($urandom_range(0, 1) == 1) tick(0, 0, 0, 1, 0, 1);
      feed_rand($urandom_range(1, 300));
      do_finish(1, 0, -1);
    end

    // Reset in the middle of a divide: aborted, no done
    feed(5, 2, 1);
    tick(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      chk("busy_pre_rst", busy, 1);
      tick(0, 1, 1, 0, 0, 0);
    end
    tick(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < DIV_CYCLES + 3; i++) tick(0, 0, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
